// File: rtl/instruction_fetch_register_if.sv
// Bus between the instruction register and its surroundings: the control
// unit (Start/Flush/Write/Sel), the byte-wide instruction memory
// (I/MemValid/MemReq/ByteIdx) and the assembled instruction outputs.
interface instruction_fetch_register_if #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_BYTES  = 2
);
    localparam int SEL_W = ($clog2(NUM_BYTES) > 1) ? $clog2(NUM_BYTES) : 1;

    logic                            Start;
    logic                            Flush;
    logic                            Write;
    logic [SEL_W-1:0]                Sel;
    logic [DATA_WIDTH-1:0]           I;
    logic                            MemValid;
    logic                            MemReq;
    logic [SEL_W-1:0]                ByteIdx;
    logic [DATA_WIDTH*NUM_BYTES-1:0] IROut;
    logic                            IRValid;
    logic                            Busy;

    // Instruction register side: consumes commands and memory bytes.
    modport slave (
        input  Start, Flush, Write, Sel, I, MemValid,
        output MemReq, ByteIdx, IROut, IRValid, Busy
    );

    // Control unit / memory side.
    modport master (
        output Start, Flush, Write, Sel, I, MemValid,
        input  MemReq, ByteIdx, IROut, IRValid, Busy
    );
endinterface

// File: rtl/instruction_fetch_register.sv
// Instruction register assembled lane by lane from a byte-serial memory.
// Direct mode writes one lane per cycle chosen by Sel; auto-fetch mode walks
// lanes 0..NUM_BYTES-1 as memory bytes arrive and flags the finished word.
module instruction_fetch_register #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_BYTES  = 2
) (
    input  logic                          Clock,
    input  logic                          Reset,
    instruction_fetch_register_if.slave   bus
);
    localparam int SEL_W = ($clog2(NUM_BYTES) > 1) ? $clog2(NUM_BYTES) : 1;
    localparam int IR_W  = DATA_WIDTH * NUM_BYTES;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [SEL_W-1:0] idx_q, idx_d;
    logic [IR_W-1:0]  ir_q, ir_d;

    logic             wr_en;
    logic [SEL_W-1:0] wr_lane;
    logic             sel_in_range;
    logic             last_lane;

    assign sel_in_range = (int'(bus.Sel) < NUM_BYTES);
    assign last_lane    = (int'(idx_q) == NUM_BYTES - 1);

    // State, lane index and instruction register update.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ir_q    <= ir_d;
        end
    end

    // Next-state and lane-write selection; Flush overrides Start, which
    // overrides memory capture, which overrides a direct write.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wr_en   = 1'b0;
        wr_lane = bus.Sel;

        if (bus.Flush) begin
            // Partially fetched lanes are kept; only the sequencer is reset.
            state_d = IDLE;
            idx_d   = '0;
        end else begin
            case (state_q)
                FETCH: begin
                    if (bus.MemValid) begin
                        wr_en   = 1'b1;
                        wr_lane = idx_q;
                        if (last_lane) begin
                            state_d = DONE;
                            idx_d   = '0;
                        end else begin
                            idx_d = idx_q + SEL_W'(1);
                        end
                    end
                end
                default: begin
                    if (bus.Start) begin
                        state_d = FETCH;
                        idx_d   = '0;
                    end else if (bus.Write && sel_in_range) begin
                        wr_en   = 1'b1;
                        wr_lane = bus.Sel;
                    end
                end
            endcase
        end
    end

    // Lane merge: only the addressed lane takes I, all others hold.
    always_comb begin
        ir_d = ir_q;
        for (int k = 0; k < NUM_BYTES; k++) begin
            if (wr_en && (int'(wr_lane) == k)) begin
                ir_d[k*DATA_WIDTH +: DATA_WIDTH] = bus.I;
            end
        end
    end

    assign bus.MemReq  = (state_q == FETCH);
    assign bus.Busy    = (state_q == FETCH);
    assign bus.IRValid = (state_q == DONE);
    assign bus.ByteIdx = idx_q;
    assign bus.IROut   = ir_q;

endmodule

// File: tb/tb_instruction_fetch_register.sv
// Bench for instruction_fetch_register: three instances (2, 3 and 4 lanes)
// share one stimulus stream; each is compared every cycle against a
// lane-array reference model, with directed checks on the instance that a
// given scenario targets.
module tb_instruction_fetch_register;

    logic clk;
    logic rst_s, start_s, flush_s, wr_s, mv_s;
    logic [1:0] sel_s;
    logic [7:0] din_s;

    int n_cmp;
    int n_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    instruction_fetch_register_if #(.DATA_WIDTH(8), .NUM_BYTES(2)) if2 ();
    instruction_fetch_register_if #(.DATA_WIDTH(8), .NUM_BYTES(3)) if3 ();
    instruction_fetch_register_if #(.DATA_WIDTH(8), .NUM_BYTES(4)) if4 ();

    assign if2.Start = start_s;  assign if3.Start = start_s;  assign if4.Start = start_s;
    assign if2.Flush = flush_s;  assign if3.Flush = flush_s;  assign if4.Flush = flush_s;
    assign if2.Write = wr_s;     assign if3.Write = wr_s;     assign if4.Write = wr_s;
    assign if2.Sel   = sel_s[0]; assign if3.Sel   = sel_s;    assign if4.Sel   = sel_s;
    assign if2.I     = din_s;    assign if3.I     = din_s;    assign if4.I     = din_s;
    assign if2.MemValid = mv_s;  assign if3.MemValid = mv_s;  assign if4.MemValid = mv_s;

    instruction_fetch_register #(.DATA_WIDTH(8), .NUM_BYTES(2)) u2 (.Clock(clk), .Reset(rst_s), .bus(if2));
    instruction_fetch_register #(.DATA_WIDTH(8), .NUM_BYTES(3)) u3 (.Clock(clk), .Reset(rst_s), .bus(if3));
    instruction_fetch_register #(.DATA_WIDTH(8), .NUM_BYTES(4)) u4 (.Clock(clk), .Reset(rst_s), .bus(if4));

    // Reference model: instance m has m+2 lanes.
    logic [7:0] mlanes [3][4];
    logic       mfetch [3];
    logic       mvalid [3];
    int         midx   [3];

    function automatic logic [31:0] model_ir(input int m);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < m + 2; k++) r[k*8 +: 8] = mlanes[m][k];
        return r;
    endfunction

    function automatic logic [36:0] model_pack(input int m);
        logic [1:0] ix;
        ix = 2'(midx[m]);
        return {model_ir(m), mvalid[m], mfetch[m], mfetch[m], ix};
    endfunction

    // {IROut, IRValid, Busy, MemReq, ByteIdx}
    function automatic logic [36:0] dut_pack(input int m);
        case (m)
            0:       return {16'h0, if2.IROut, if2.IRValid, if2.Busy, if2.MemReq, 1'b0, if2.ByteIdx};
            1:       return {8'h0,  if3.IROut, if3.IRValid, if3.Busy, if3.MemReq, if3.ByteIdx};
            default: return {       if4.IROut, if4.IRValid, if4.Busy, if4.MemReq, if4.ByteIdx};
        endcase
    endfunction

    task automatic model_step(input int m);
        int nb;
        int s;
        nb = m + 2;
        if (rst_s) begin
            for (int k = 0; k < 4; k++) mlanes[m][k] = 8'h00;
            mfetch[m] = 1'b0; mvalid[m] = 1'b0; midx[m] = 0;
        end else if (flush_s) begin
            mfetch[m] = 1'b0; mvalid[m] = 1'b0; midx[m] = 0;
        end else if (mfetch[m]) begin
            if (mv_s) begin
                mlanes[m][midx[m]] = din_s;
                if (midx[m] == nb - 1) begin
                    mfetch[m] = 1'b0; mvalid[m] = 1'b1; midx[m] = 0;
                end else begin
                    midx[m] = midx[m] + 1;
                end
            end
        end else if (start_s) begin
            mfetch[m] = 1'b1; mvalid[m] = 1'b0; midx[m] = 0;
        end else if (wr_s) begin
            s = (nb == 2) ? int'(sel_s[0]) : int'(sel_s);
            if (s < nb) mlanes[m][s] = din_s;
        end
    endtask

    // Apply one cycle of inputs, advance the model, then compare all instances.
    task automatic tick(input logic r, input logic st, input logic fl, input logic wr,
                        input logic [1:0] s, input logic [7:0] d, input logic mv);
        logic [36:0] act, exp;
        rst_s = r; start_s = st; flush_s = fl; wr_s = wr; sel_s = s; din_s = d; mv_s = mv;
        @(posedge clk);
        for (int m = 0; m < 3; m++) model_step(m);
        #1;
        for (int m = 0; m < 3; m++) begin
            act = dut_pack(m);
            exp = model_pack(m);
            n_cmp++;
            if (act !== exp) begin
                n_err++;
                $display("FAIL model_nb%0d t=%0t got ir=%h v/b/r=%b%b%b idx=%0d want ir=%h v/b/r=%b%b%b idx=%0d",
                         m + 2, $time, act[36:5], act[4], act[3], act[2], act[1:0],
                         exp[36:5], exp[4], exp[3], exp[2], exp[1:0]);
            end
        end
    endtask

    task automatic chk(input int m, input string name, input logic [31:0] ir,
                       input logic v, input logic b, input logic [1:0] ix);
        logic [36:0] act, exp;
        act = dut_pack(m);
        exp = {ir, v, b, b, ix};
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s nb%0d got ir=%h v/b/r=%b%b%b idx=%0d want ir=%h v=%b b=%b idx=%0d",
                     name, m + 2, act[36:5], act[4], act[3], act[2], act[1:0], ir, v, b, ix);
        end
    endtask

    typedef struct {
        logic       r, st, fl, wr;
        logic [1:0] sel;
        logic [7:0] din;
        logic       mv;
        int         dut;
        logic [31:0] ir;
        logic       v, b;
        logic [1:0] idx;
    } vec_t;

    vec_t vecs [14];

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_s = 1'b1; start_s = 1'b0; flush_s = 1'b0; wr_s = 1'b0;
        sel_s = 2'd0; din_s = 8'h00; mv_s = 1'b0;
        for (int m = 0; m < 3; m++) begin
            for (int k = 0; k < 4; k++) mlanes[m][k] = 8'h00;
            mfetch[m] = 1'b0; mvalid[m] = 1'b0; midx[m] = 0;
        end

        //            r  st fl wr sel din    mv dut ir            v  b  idx
        vecs[0]  = '{1, 0, 0, 0, 0, 8'h00, 0, 0, 32'h0,        0, 0, 0};
        vecs[1]  = '{1, 0, 0, 0, 0, 8'h00, 0, 2, 32'h0,        0, 0, 0};
        vecs[2]  = '{0, 1, 0, 0, 0, 8'h00, 0, 0, 32'h0,        0, 1, 0};
        vecs[3]  = '{0, 0, 0, 0, 0, 8'h34, 1, 0, 32'h0034,     0, 1, 1};
        vecs[4]  = '{0, 0, 0, 0, 0, 8'h12, 1, 0, 32'h1234,     1, 0, 0};
        vecs[5]  = '{0, 0, 0, 0, 0, 8'h00, 0, 0, 32'h1234,     1, 0, 0};
        vecs[6]  = '{1, 0, 0, 0, 0, 8'h00, 0, 0, 32'h0,        0, 0, 0};
        vecs[7]  = '{0, 0, 0, 1, 1, 8'hAB, 0, 0, 32'hAB00,     0, 0, 0};
        vecs[8]  = '{0, 0, 0, 1, 0, 8'hCD, 0, 0, 32'hABCD,     0, 0, 0};
        vecs[9]  = '{0, 0, 0, 0, 0, 8'h00, 0, 2, 32'h0000ABCD, 0, 0, 0};
        vecs[10] = '{0, 1, 0, 0, 0, 8'h00, 0, 0, 32'hABCD,     0, 1, 0};
        vecs[11] = '{0, 0, 0, 1, 1, 8'hEE, 0, 0, 32'hABCD,     0, 1, 0};
        vecs[12] = '{0, 0, 1, 0, 0, 8'h00, 0, 0, 32'hABCD,     0, 0, 0};
        vecs[13] = '{0, 0, 0, 0, 0, 8'h55, 1, 0, 32'hABCD,     0, 0, 0};

        // Reset, 2-lane fetch and direct-mode writes.
        for (int i = 0; i < 14; i++) begin
            tick(vecs[i].r, vecs[i].st, vecs[i].fl, vecs[i].wr, vecs[i].sel, vecs[i].din, vecs[i].mv);
            chk(vecs[i].dut, $sformatf("vec%0d", i), vecs[i].ir, vecs[i].v, vecs[i].b, vecs[i].idx);
        end

        // 4-lane fetch with two wait cycles before the third byte.
        tick(0, 1, 0, 0, 0, 8'h00, 0);
        tick(0, 0, 0, 0, 0, 8'hDD, 1);
        tick(0, 0, 0, 0, 0, 8'hCC, 1);
        chk(2, "wait_enter", 32'h0000CCDD, 0, 1, 2);
        tick(0, 0, 0, 0, 0, 8'h00, 0);
        chk(2, "wait1", 32'h0000CCDD, 0, 1, 2);
        tick(0, 0, 0, 0, 0, 8'h00, 0);
        chk(2, "wait2", 32'h0000CCDD, 0, 1, 2);
        tick(0, 0, 0, 0, 0, 8'hBB, 1);
        chk(2, "lane2", 32'h00BBCCDD, 0, 1, 3);
        tick(0, 0, 0, 0, 0, 8'hAA, 1);
        chk(2, "fetch4_done", 32'hAABBCCDD, 1, 0, 0);

        // Flush after a partial fetch keeps captured lanes and drops the same-cycle byte.
        tick(0, 0, 0, 1, 0, 8'h44, 0);
        tick(0, 0, 0, 1, 1, 8'h33, 0);
        tick(0, 0, 0, 1, 2, 8'h22, 0);
        tick(0, 0, 0, 1, 3, 8'h11, 0);
        chk(2, "direct_in_done", 32'h11223344, 1, 0, 0);
        tick(0, 1, 0, 0, 0, 8'h00, 0);
        tick(0, 0, 0, 0, 0, 8'h99, 1);
        chk(2, "partial", 32'h11223399, 0, 1, 1);
        tick(0, 0, 1, 0, 0, 8'h77, 1);
        chk(2, "flush", 32'h11223399, 0, 0, 0);

        // Start beats Write in DONE, then reset mid-fetch.
        tick(0, 1, 0, 0, 0, 8'h00, 0);
        tick(0, 0, 0, 0, 0, 8'h34, 1);
        tick(0, 0, 0, 0, 0, 8'h12, 1);
        chk(0, "refetch", 32'h1234, 1, 0, 0);
        tick(0, 1, 0, 1, 0, 8'hFF, 0);
        chk(0, "start_wins", 32'h1234, 0, 1, 0);
        tick(0, 0, 0, 0, 0, 8'h56, 1);
        chk(0, "midfetch", 32'h1256, 0, 1, 1);
        tick(1, 0, 0, 0, 0, 8'h00, 0);
        chk(0, "reset_mid2", 32'h0, 0, 0, 0);
        chk(2, "reset_mid4", 32'h0, 0, 0, 0);

        // 3-lane: out-of-range direct write, then auto-fetch.
        tick(0, 0, 0, 1, 3, 8'hEE, 0);
        chk(1, "sel_oob", 32'h0, 0, 0, 0);
        tick(0, 1, 0, 0, 0, 8'h00, 0);
        tick(0, 0, 0, 0, 0, 8'h01, 1);
        tick(0, 0, 0, 0, 0, 8'h02, 1);
        chk(1, "nb3_lane1", 32'h000201, 0, 1, 2);
        tick(0, 0, 0, 0, 0, 8'h03, 1);
        chk(1, "nb3_done", 32'h030201, 1, 0, 0);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            tick(($urandom % 64) == 0, ($urandom % 6) == 0, ($urandom % 20) == 0,
                 ($urandom % 3) == 0, 2'($urandom), 8'($urandom), ($urandom % 3) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_register.md
Name: instruction_fetch_register

Overview:
Parametrised instruction register that assembles an instruction of NUM_BYTES lanes, each DATA_WIDTH bits, from a byte-serial memory port. It supports two modes:
- Direct mode: one lane is written per cycle, selected by Sel.
- Auto-fetch mode: a sequencer requests lanes 0..NUM_BYTES-1 in order and flags a complete instruction.

It sits between the byte-wide instruction memory and the control unit.

Parameters:
DATA_WIDTH, 8, width of one lane and of input I.
NUM_BYTES, 2, lanes per instruction; must be >= 2. IROut width = DATA_WIDTH*NUM_BYTES.
SEL_W, derived = max(1, clog2(NUM_BYTES)), width of Sel and ByteIdx; not overridable.

Ports:
Clock  input  1  rising-edge clock.
Reset  input  1  synchronous reset, active-high.
Start  input  1  begin auto-fetch of a new instruction.
Flush  input  1  abort fetch and invalidate the instruction.
Write  input  1  direct-mode lane write enable.
Sel  input  SEL_W  lane index for direct write.
I  input  DATA_WIDTH  data byte, used by both modes.
MemValid  input  1  memory presents lane ByteIdx on I this cycle.
MemReq  output  1  sequencer requesting lane ByteIdx.
ByteIdx  output  SEL_W  lane currently requested.
IROut  output  DATA_WIDTH*NUM_BYTES  assembled instruction; lane k = bits [(k+1)*DATA_WIDTH-1 : k*DATA_WIDTH].
IRValid  output  1  IROut holds a complete auto-fetched instruction.
Busy  output  1  sequencer in FETCH.

Behaviour:
- Reset values (all state updates on the rising edge of Clock; Reset sampled synchronously): state IDLE, IROut = 0, IRValid = 0, MemReq = 0, ByteIdx = 0, Busy = 0.
- Priority per cycle: Reset > Flush > Start > MemValid capture > Write.
- Outputs are Moore/registered: MemReq = Busy = (state == FETCH); IRValid = (state == DONE).
- FSM states: IDLE, FETCH, DONE.
- IDLE / DONE:
  - Start -> FETCH with ByteIdx = 0 and IRValid dropping on the same edge.
  - Write with Sel < NUM_BYTES writes I to lane Sel; other lanes are held. State is unchanged, so IRValid is unaffected.
  - Write with Sel >= NUM_BYTES is ignored.
  - MemValid is ignored.
- FETCH:
  - MemValid=1 writes I into lane ByteIdx.
  - If ByteIdx == NUM_BYTES-1: go to DONE and set ByteIdx = 0. Otherwise increment ByteIdx.
  - MemValid=0 holds both state and ByteIdx (wait states are unlimited).
  - Start and Write are ignored.
- Flush in any state -> IDLE, with IRValid = 0 and ByteIdx = 0. IROut is retained, including partially fetched lanes. A MemValid in the same cycle is not captured.
- Start and Write in the same cycle in IDLE/DONE: Start wins and the write is dropped.
- Latency: Start sampled on edge e0 means MemReq is high after e0. With MemValid on every following edge, the last lane is captured on edge eNUM_BYTES and IRValid is high after that same edge.
- Reset mid-fetch has the full reset effect: IROut is cleared.
- Lanes not yet fetched keep their previous contents until overwritten.

Test Plan:
1. Reset, then DATA_WIDTH=8, NUM_BYTES=2. Start; MemValid=1 with I=0x34 then 0x12 on consecutive edges -> IROut=0x1234; IRValid rises after the 2nd capture edge; MemReq high exactly 2 cycles; ByteIdx sequence 0,1.
2. NUM_BYTES=4. Start; feed 0xDD, 0xCC, 0xBB, 0xAA with two MemValid=0 wait cycles before the 3rd byte -> ByteIdx holds at 2 during the waits; IROut=0xAABBCCDD; IRValid high after the 4th capture; Busy low afterwards.
3. NUM_BYTES=2 direct mode from reset:
   - Write Sel=1, I=0xAB, then Sel=0, I=0xCD -> IROut=0xABCD and IRValid stays 0.
   - Write with Sel=1 while Busy -> IROut unchanged.
4. NUM_BYTES=4, prior IROut=0x11223344. Start; capture lane 0 = 0x99; assert Flush together with MemValid and I=0x77 -> state IDLE, IRValid=0, IROut=0x11223399.
5. In DONE with IROut=0x1234: assert Start and Write (Sel=0, I=0xFF) together -> FETCH entered, IRValid low, IROut still 0x1234. Then assert Reset mid-fetch -> IROut=0, all outputs at reset values.
6. NUM_BYTES=3 (SEL_W=2): direct Write with Sel=3 -> ignored, IROut unchanged. Auto-fetch of 0x01, 0x02, 0x03 -> IROut=0x030201.
